// File: rtl/vga_sprite_overlay_if.sv
// -----------------------------------------------------------------------------
// vga_sprite_overlay_if
// Sprite attribute configuration port for vga_sprite_overlay.
//   cfg_valid  master -> slave  write request
//   cfg_ready  slave  -> master write accepted when high with cfg_valid
//   cfg_sel    master -> slave  sprite index (3 bits)
//   cfg_field  master -> slave  0=X, 1=Y, 2=colour, 3=enable, 4=mask row
//   cfg_mrow   master -> slave  mask row index (mask row writes only)
//   cfg_data   master -> slave  write data (16 bits)
// -----------------------------------------------------------------------------
interface vga_sprite_overlay_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_sel;
  logic [2:0]  cfg_field;
  logic [2:0]  cfg_mrow;
  logic [15:0] cfg_data;

  modport master (
    output cfg_valid, cfg_sel, cfg_field, cfg_mrow, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_field, cfg_mrow, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/vga_sprite_overlay.sv
// -----------------------------------------------------------------------------
// vga_sprite_overlay
// Pixel pipeline stage compositing up to NUM_SPRITES 1bpp sprites over the
// framebuffer pixel stream and driving the VGA pins. Sprite attributes are
// double-buffered: writes land in a shadow set that is copied to the active
// set on the leading edge of vertical sync.
//
// Ports:
//   vga_clk, wb_rst_i      pixel clock, asynchronous active-high reset
//   in_pix                 framebuffer pixel {b[1:0],g[2:0],r[2:0]}
//   in_row, in_col         current pixel coordinates
//   in_video_on            active display region
//   in_hs, in_vs           syncs from the timing generator (level SYNC_POL)
//   cfg                    configuration port (vga_sprite_overlay_if.slave)
//   vga_r/g/b              4-bit colour outputs (2-cycle latency)
//   vga_hs, vga_vs         syncs delayed to match the pixel path
//   frame_start_o          one-cycle pulse in the cycle after a commit
//   collision_o            previous frame had a sprite-sprite overlap
//
// Build option: define SPRITE_COLLISION_EN to include the collision
// accumulator; otherwise collision_o is tied low.
// -----------------------------------------------------------------------------
module vga_sprite_overlay #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 8,
  parameter int COORD_W     = 12,
  parameter int SYNC_POL    = 0
) (
  input  logic               vga_clk,
  input  logic               wb_rst_i,
  input  logic [7:0]         in_pix,
  input  logic [COORD_W-1:0] in_row,
  input  logic [COORD_W-1:0] in_col,
  input  logic               in_video_on,
  input  logic               in_hs,
  input  logic               in_vs,
  vga_sprite_overlay_if.slave cfg,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start_o,
  output logic               collision_o
);

  localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic SYNC_ACT = (SYNC_POL != 0);
  localparam logic [COORD_W:0] SPR_W_C = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] SPR_H_C = (COORD_W+1)'(SPR_H);

  // Commit on the first cycle in_vs is active. The previous-state flop resets
  // to "active" so a reset released during vsync waits for the next edge.
  logic vs_act_prev_reg;
  logic commit;
  logic cfg_wr;

  assign commit        = (in_vs == SYNC_ACT) & ~vs_act_prev_reg;
  assign cfg.cfg_ready = ~commit;
  assign cfg_wr        = cfg.cfg_valid & cfg.cfg_ready;

  // Stage 1 registers shared by all sprites
  logic [7:0] s1_pix_reg;
  logic       s1_von_reg;
  logic       s1_hs_reg;
  logic       s1_vs_reg;
  logic       frame_start_reg;

  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vs_act_prev_reg <= 1'b1;
      s1_pix_reg      <= '0;
      s1_von_reg      <= 1'b0;
      s1_hs_reg       <= ~SYNC_ACT;
      s1_vs_reg       <= ~SYNC_ACT;
      frame_start_reg <= 1'b0;
    end else begin
      vs_act_prev_reg <= (in_vs == SYNC_ACT);
      s1_pix_reg      <= in_pix;
      s1_von_reg      <= in_video_on;
      s1_hs_reg       <= in_hs;
      s1_vs_reg       <= in_vs;
      frame_start_reg <= commit;
    end
  end

  assign frame_start_o = frame_start_reg;

  // Per-sprite attribute storage, hit test (stage 1) and mask lookup (stage 2)
  logic [NUM_SPRITES-1:0] opaque;
  logic [7:0]             spr_colour [NUM_SPRITES];

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
    logic [COORD_W-1:0] sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
    logic [7:0]         sh_col_reg, act_col_reg;
    logic               sh_en_reg, act_en_reg;
    logic [SPR_W-1:0]   sh_mask_reg  [SPR_H];
    logic [SPR_W-1:0]   act_mask_reg [SPR_H];
    logic               sel_hit;
    logic [COORD_W:0]   dx, dy;
    logic               hit_next;
    logic               s1_hit_reg;
    logic [DXW-1:0]     s1_dx_reg;
    logic [DYW-1:0]     s1_dy_reg;
    logic [SPR_W-1:0]   row_bits;

    assign sel_hit = cfg_wr && (cfg.cfg_sel == 3'(gi));

    // Commit never coincides with a write because cfg_ready is low then.
    always_ff @(posedge vga_clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        sh_x_reg    <= '0;
        sh_y_reg    <= '0;
        sh_col_reg  <= '0;
        sh_en_reg   <= 1'b0;
        act_x_reg   <= '0;
        act_y_reg   <= '0;
        act_col_reg <= '0;
        act_en_reg  <= 1'b0;
        for (int r = 0; r < SPR_H; r++) begin
          sh_mask_reg[r]  <= '0;
          act_mask_reg[r] <= '0;
        end
      end else begin
        if (sel_hit) begin
          case (cfg.cfg_field)
            3'd0: sh_x_reg   <= cfg.cfg_data[COORD_W-1:0];
            3'd1: sh_y_reg   <= cfg.cfg_data[COORD_W-1:0];
            3'd2: sh_col_reg <= cfg.cfg_data[7:0];
            3'd3: sh_en_reg  <= cfg.cfg_data[0];
            3'd4: begin
              if (32'(cfg.cfg_mrow) < SPR_H)
                sh_mask_reg[DYW'(cfg.cfg_mrow)] <= cfg.cfg_data[SPR_W-1:0];
            end
            default: ;
          endcase
        end
        if (commit) begin
          act_x_reg   <= sh_x_reg;
          act_y_reg   <= sh_y_reg;
          act_col_reg <= sh_col_reg;
          act_en_reg  <= sh_en_reg;
          for (int r = 0; r < SPR_H; r++)
            act_mask_reg[r] <= sh_mask_reg[r];
        end
      end
    end

    // One extra bit keeps the sign so pixels left/above the sprite miss.
    assign dx = {1'b0, in_col} - {1'b0, act_x_reg};
    assign dy = {1'b0, in_row} - {1'b0, act_y_reg};
    assign hit_next = act_en_reg & ~dx[COORD_W] & ~dy[COORD_W]
                    & (dx < SPR_W_C) & (dy < SPR_H_C);

    always_ff @(posedge vga_clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        s1_hit_reg <= 1'b0;
        s1_dx_reg  <= '0;
        s1_dy_reg  <= '0;
      end else begin
        s1_hit_reg <= hit_next;
        s1_dx_reg  <= dx[DXW-1:0];
        s1_dy_reg  <= dy[DYW-1:0];
      end
    end

    // Mask MSB is the leftmost pixel.
    assign row_bits       = act_mask_reg[s1_dy_reg];
    assign opaque[gi]     = s1_hit_reg & row_bits[DXW'(SPR_W-1) - s1_dx_reg];
    assign spr_colour[gi] = act_col_reg;
  end

  // Stage 2: lowest-index opaque sprite wins; scanning downward lets it
  // overwrite any higher-index candidate.
  logic [7:0]  win_colour;
  logic [11:0] rgb_next;

  always_comb begin
    win_colour = s1_pix_reg;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i])
        win_colour = spr_colour[i];
    end
    rgb_next = '0;
    if (s1_von_reg)
      rgb_next = {{1'b0, win_colour[2:0]}, {1'b0, win_colour[5:3]}, {2'b00, win_colour[7:6]}};
  end

  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= ~SYNC_ACT;
      vga_vs <= ~SYNC_ACT;
    end else begin
      vga_r  <= rgb_next[11:8];
      vga_g  <= rgb_next[7:4];
      vga_b  <= rgb_next[3:0];
      vga_hs <= s1_hs_reg;
      vga_vs <= s1_vs_reg;
    end
  end

`ifdef SPRITE_COLLISION_EN
  // x & (x-1) is non-zero exactly when two or more bits are set.
  logic overlap;
  logic coll_acc_reg;
  logic collision_reg;

  assign overlap = s1_von_reg & (|(opaque & (opaque - NUM_SPRITES'(1))));

  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      coll_acc_reg  <= 1'b0;
      collision_reg <= 1'b0;
    end else if (commit) begin
      collision_reg <= coll_acc_reg;
      coll_acc_reg  <= overlap;
    end else begin
      coll_acc_reg  <= coll_acc_reg | overlap;
    end
  end

  assign collision_o = collision_reg;
`else
  assign collision_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// -----------------------------------------------------------------------------
// tb_vga_sprite_overlay
// Directed bench for vga_sprite_overlay: passthrough, double-buffered commit,
// priority and collision, right-edge clipping, commit stall and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_vga_sprite_overlay;
  localparam int COORD_W = 12;

`ifdef SPRITE_COLLISION_EN
  localparam logic COLL_ON = 1'b1;
`else
  localparam logic COLL_ON = 1'b0;
`endif

  logic               vga_clk = 1'b0;
  logic               wb_rst_i;
  logic [7:0]         in_pix;
  logic [COORD_W-1:0] in_row;
  logic [COORD_W-1:0] in_col;
  logic               in_video_on;
  logic               in_hs;
  logic               in_vs;
  logic [3:0]         vga_r, vga_g, vga_b;
  logic               vga_hs, vga_vs;
  logic               frame_start_o;
  logic               collision_o;

  int total = 0;
  int bad   = 0;

  vga_sprite_overlay_if cfg_bus ();

  vga_sprite_overlay #(
    .NUM_SPRITES(4), .SPR_W(16), .SPR_H(8), .COORD_W(COORD_W), .SYNC_POL(0)
  ) dut (
    .vga_clk      (vga_clk),
    .wb_rst_i     (wb_rst_i),
    .in_pix       (in_pix),
    .in_row       (in_row),
    .in_col       (in_col),
    .in_video_on  (in_video_on),
    .in_hs        (in_hs),
    .in_vs        (in_vs),
    .cfg          (cfg_bus),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .frame_start_o(frame_start_o),
    .collision_o  (collision_o)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    if (obs === exp) $display("check %-14s observed=%0h", tag, obs);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [2:0] field,
                           input logic [2:0] mrow, input logic [15:0] data);
    int n;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_sel   = sel;
    cfg_bus.cfg_field = field;
    cfg_bus.cfg_mrow  = mrow;
    cfg_bus.cfg_data  = data;
    #1;
    n = 0;
    while (cfg_bus.cfg_ready !== 1'b1 && n < 8) begin
      @(negedge vga_clk);
      #1;
      n++;
    end
    if (n >= 8) begin
      total++;
      bad++;
      $error("FAIL cfg_wait observed=%b expected=1", cfg_bus.cfg_ready);
    end
    @(negedge vga_clk);
    cfg_bus.cfg_valid = 1'b0;
    $display("cfg write sel=%0d field=%0d mrow=%0d data=%0h", sel, field, mrow, data);
  endtask

  task automatic fill_mask(input logic [2:0] sel, input logic [15:0] data);
    for (int r = 0; r < 8; r++) cfg_write(sel, 3'd4, 3'(r), data);
  endtask

  task automatic commit_pulse();
    in_vs = 1'b0;
    step(2);
    in_vs = 1'b1;
    step(2);
  endtask

  task automatic px(input string tag, input int row, input int col, input logic [7:0] pix,
                    input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    in_row      = COORD_W'(row);
    in_col      = COORD_W'(col);
    in_pix      = pix;
    in_video_on = 1'b1;
    step(2);
    chk({tag, ".r"}, vga_r, er);
    chk({tag, ".g"}, vga_g, eg);
    chk({tag, ".b"}, vga_b, eb);
    in_video_on = 1'b0;
  endtask

  initial begin
    wb_rst_i          = 1'b1;
    in_pix            = 8'h00;
    in_row            = '0;
    in_col            = '0;
    in_video_on       = 1'b0;
    in_hs             = 1'b1;
    in_vs             = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_sel   = 3'd0;
    cfg_bus.cfg_field = 3'd0;
    cfg_bus.cfg_mrow  = 3'd0;
    cfg_bus.cfg_data  = 16'h0000;
    step(3);

    // Reset state
    chk("rst.r", vga_r, 4'h0);
    chk("rst.g", vga_g, 4'h0);
    chk("rst.b", vga_b, 4'h0);
    chk("rst.hs", vga_hs, 1'b1);
    chk("rst.vs", vga_vs, 1'b1);
    chk("rst.fs", frame_start_o, 1'b0);
    chk("rst.coll", collision_o, 1'b0);
    chk("rst.ready", cfg_bus.cfg_ready, 1'b1);
    wb_rst_i = 1'b0;
    step(2);

    // Passthrough, blanking and sync delay
    px("pass", 0, 0, 8'hC7, 4'h7, 4'h0, 4'h3);
    in_pix = 8'hC7;
    step(2);
    chk("blank.r", vga_r, 4'h0);
    chk("blank.b", vga_b, 4'h0);
    in_hs = 1'b0;
    step(1);
    chk("hs.d1", vga_hs, 1'b1);
    step(1);
    chk("hs.d2", vga_hs, 1'b0);
    in_hs = 1'b1;
    step(2);
    chk("hs.back", vga_hs, 1'b1);

    // Double buffer: sprite 0 written mid-frame
    cfg_write(3'd0, 3'd0, 3'd0, 16'd100);
    cfg_write(3'd0, 3'd1, 3'd0, 16'd50);
    cfg_write(3'd0, 3'd2, 3'd0, 16'h0038);
    cfg_write(3'd0, 3'd3, 3'd0, 16'h0001);
    fill_mask(3'd0, 16'hFFFF);
    px("pre_vs", 50, 100, 8'hC7, 4'h7, 4'h0, 4'h3);
    in_vs = 1'b0;
    #1;
    chk("vs.ready0", cfg_bus.cfg_ready, 1'b0);
    step(1);
    chk("vs.fs1", frame_start_o, 1'b1);
    chk("vs.ready1", cfg_bus.cfg_ready, 1'b1);
    chk("vs.dly1", vga_vs, 1'b1);
    step(1);
    chk("vs.fs0", frame_start_o, 1'b0);
    chk("vs.dly2", vga_vs, 1'b0);
    in_vs = 1'b1;
    step(2);
    px("s0.hit", 50, 100, 8'hC7, 4'h0, 4'h7, 4'h0);
    px("s0.right", 50, 116, 8'hC7, 4'h7, 4'h0, 4'h3);
    px("s0.corner", 57, 115, 8'hC7, 4'h0, 4'h7, 4'h0);
    px("s0.below", 58, 100, 8'hC7, 4'h7, 4'h0, 4'h3);
    px("s0.above", 49, 100, 8'hC7, 4'h7, 4'h0, 4'h3);

    // Priority: sprite 0 (colour 07, leftmost pixel of row 0 clear) over sprite 1
    cfg_write(3'd0, 3'd0, 3'd0, 16'd10);
    cfg_write(3'd0, 3'd1, 3'd0, 16'd10);
    cfg_write(3'd0, 3'd2, 3'd0, 16'h0007);
    cfg_write(3'd0, 3'd4, 3'd0, 16'h7FFF);
    cfg_write(3'd1, 3'd0, 3'd0, 16'd10);
    cfg_write(3'd1, 3'd1, 3'd0, 16'd10);
    cfg_write(3'd1, 3'd2, 3'd0, 16'h0038);
    cfg_write(3'd1, 3'd3, 3'd0, 16'h0001);
    fill_mask(3'd1, 16'hFFFF);
    cfg_write(3'd7, 3'd3, 3'd0, 16'h0001);
    cfg_write(3'd0, 3'd6, 3'd0, 16'h0000);
    commit_pulse();
    chk("coll.none", collision_o, 1'b0);
    px("pri.s1only", 10, 10, 8'h00, 4'h0, 4'h7, 4'h0);
    px("pri.both", 10, 11, 8'h00, 4'h7, 4'h0, 4'h0);
    px("pri.row1", 11, 10, 8'h00, 4'h7, 4'h0, 4'h0);
    commit_pulse();
    chk("coll.set", collision_o, COLL_ON);
    cfg_write(3'd1, 3'd3, 3'd0, 16'h0000);
    commit_pulse();
    chk("coll.clear", collision_o, 1'b0);
    px("pri.s0alone", 10, 11, 8'h00, 4'h7, 4'h0, 4'h0);
    px("pri.transp", 10, 10, 8'h01, 4'h1, 4'h0, 4'h0);

    // Clipping at the right edge of a 640-wide frame
    cfg_write(3'd2, 3'd0, 3'd0, 16'd632);
    cfg_write(3'd2, 3'd1, 3'd0, 16'd20);
    cfg_write(3'd2, 3'd2, 3'd0, 16'h00C0);
    cfg_write(3'd2, 3'd3, 3'd0, 16'h0001);
    cfg_write(3'd2, 3'd4, 3'd0, 16'hFFFF);
    commit_pulse();
    px("clip.632", 20, 632, 8'h00, 4'h0, 4'h0, 4'h3);
    px("clip.639", 20, 639, 8'h00, 4'h0, 4'h0, 4'h3);
    px("clip.col0", 20, 0, 8'h01, 4'h1, 4'h0, 4'h0);

    // Commit stall: enable write held across the vs edge
    cfg_write(3'd3, 3'd0, 3'd0, 16'd200);
    cfg_write(3'd3, 3'd1, 3'd0, 16'd30);
    cfg_write(3'd3, 3'd2, 3'd0, 16'h0038);
    cfg_write(3'd3, 3'd4, 3'd0, 16'hFFFF);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_sel   = 3'd3;
    cfg_bus.cfg_field = 3'd3;
    cfg_bus.cfg_mrow  = 3'd0;
    cfg_bus.cfg_data  = 16'h0001;
    in_vs = 1'b0;
    #1;
    chk("stall.ready0", cfg_bus.cfg_ready, 1'b0);
    step(1);
    chk("stall.ready1", cfg_bus.cfg_ready, 1'b1);
    step(1);
    cfg_bus.cfg_valid = 1'b0;
    $display("cfg write sel=3 field=3 mrow=0 data=1 (held across commit)");
    in_vs = 1'b1;
    step(2);
    px("stall.shadow", 30, 200, 8'hC7, 4'h7, 4'h0, 4'h3);
    commit_pulse();
    px("stall.active", 30, 200, 8'hC7, 4'h0, 4'h7, 4'h0);

    // Reset during an active sprite pixel
    in_row      = COORD_W'(30);
    in_col      = COORD_W'(200);
    in_pix      = 8'hC7;
    in_video_on = 1'b1;
    step(2);
    chk("mrst.pre.g", vga_g, 4'h7);
    wb_rst_i = 1'b1;
    #1;
    chk("mrst.r", vga_r, 4'h0);
    chk("mrst.g", vga_g, 4'h0);
    chk("mrst.b", vga_b, 4'h0);
    chk("mrst.ready", cfg_bus.cfg_ready, 1'b1);
    step(1);
    wb_rst_i = 1'b0;
    step(2);
    chk("mrst.post.r", vga_r, 4'h7);
    chk("mrst.post.g", vga_g, 4'h0);
    chk("mrst.post.b", vga_b, 4'h3);
    in_video_on = 1'b0;
    in_vs = 1'b0;
    step(1);
    chk("mrst.fs", frame_start_o, 1'b1);
    step(1);
    in_vs = 1'b1;
    step(2);
    chk("mrst.coll", collision_o, 1'b0);
    px("mrst.off", 30, 200, 8'hC7, 4'h7, 4'h0, 4'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
